// File: rtl/bp_table_ctrl.sv
// Branch-predictor counter table: 2-bit saturating counters behind a single access port,
// shared between fetch lookups and FIFO-buffered read-modify-write updates from execute.
module bp_table_ctrl #(
  parameter int IDX_BITS   = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        lk_req,
  input  logic [31:0] lk_pc,
  output logic        lk_ready,
  output logic        lk_vld,
  output logic        lk_pred,
  input  logic        up_valid,
  input  logic [31:0] up_pc,
  input  logic        up_taken,
  output logic        up_ready,
  output logic        busy_init,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens in a cycle where valid/req and ready are both high at
  // the rising edge; ready never depends on valid/req of the same interface.

  localparam int ENTRIES = 2 ** IDX_BITS;
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CW      = PW + 1;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_BITS-1:0]   sweep_q, sweep_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  lk_vld_q, lk_pred_q;

  logic [1:0]            table_q [ENTRIES];
  logic [IDX_BITS-1:0]   fifo_idx_q [FIFO_DEPTH];
  logic                  fifo_tkn_q [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]         count_q, count_d;

  logic                  fifo_full, fifo_empty;
  logic                  lk_grant, push, pop;
  logic [IDX_BITS-1:0]   lk_idx, up_idx, head_idx;
  logic                  head_tkn;
  logic [IDX_BITS-1:0]   rd_addr;
  logic [1:0]            rd_data;
  logic                  tbl_we;
  logic [IDX_BITS-1:0]   tbl_waddr;
  logic [1:0]            tbl_wdata;
  logic                  unused_pc_bits;

  function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? c : c + 2'd1;
    else   return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  assign lk_idx   = lk_pc[IDX_BITS+1:2];
  assign up_idx   = up_pc[IDX_BITS+1:2];
  assign head_idx = fifo_idx_q[rd_ptr_q];
  assign head_tkn = fifo_tkn_q[rd_ptr_q];
  assign unused_pc_bits = ^{lk_pc[31:IDX_BITS+2], lk_pc[1:0], up_pc[31:IDX_BITS+2], up_pc[1:0]};

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  assign lk_ready  = (state_q != ST_INIT) && !fifo_full;
  assign up_ready  = !fifo_full;
  assign busy_init = (state_q == ST_INIT);
  assign lk_vld    = lk_vld_q;
  assign lk_pred   = lk_pred_q;
  assign dbg_state = state_q;

  // A granted lookup owns the port; otherwise the update engine may use it.
  assign lk_grant = lk_req && lk_ready;
  assign push     = up_valid && !fifo_full;
  assign rd_addr  = lk_grant ? lk_idx : head_idx;
  assign rd_data  = table_q[rd_addr];

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == {IDX_BITS{1'b1}}) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!fifo_empty && !lk_grant) begin
          cnt_d   = rd_data;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        if (!lk_grant) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = sweep_q;
    tbl_wdata = 2'b00;
    if (state_q == ST_INIT) begin
      tbl_we = 1'b1;
    end else if (pop) begin
      tbl_we    = 1'b1;
      tbl_waddr = head_idx;
      tbl_wdata = sat(cnt_q, head_tkn);
    end
  end

  // Push is blocked while full even if a pop lands in the same cycle.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_INIT;
      sweep_q   <= '0;
      cnt_q     <= 2'b00;
      lk_vld_q  <= 1'b0;
      lk_pred_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      cnt_q    <= cnt_d;
      lk_vld_q <= lk_grant;
      if (lk_grant) lk_pred_q <= rd_data[1];
      if (push)     wr_ptr_q  <= wr_ptr_q + 1'b1;
      if (pop)      rd_ptr_q  <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage arrays carry no reset: the sweep clears the table and count_q gates the FIFO.
  always_ff @(posedge CLK) begin
    if (tbl_we) table_q[tbl_waddr] <= tbl_wdata;
    if (push) begin
      fifo_idx_q[wr_ptr_q] <= up_idx;
      fifo_tkn_q[wr_ptr_q] <= up_taken;
    end
  end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Directed bench for bp_table_ctrl: init sweep, counter saturation, aliasing,
// port contention, read/write hazard and mid-operation reset.
module tb_bp_table_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        lk_req = 1'b0;
  logic [31:0] lk_pc = '0;
  logic        lk_ready, lk_vld, lk_pred;
  logic        up_valid = 1'b0;
  logic [31:0] up_pc = '0;
  logic        up_taken = 1'b0;
  logic        up_ready, busy_init;
  logic [1:0]  dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [1:0] S_INIT = 2'd0, S_WR = 2'd2;

  bp_table_ctrl #(.IDX_BITS(10), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .lk_req(lk_req), .lk_pc(lk_pc), .lk_ready(lk_ready), .lk_vld(lk_vld), .lk_pred(lk_pred),
    .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken), .up_ready(up_ready),
    .busy_init(busy_init), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Lookup on a free port: response next cycle, then lk_pred must hold.
  task automatic lookup(input string tag, input logic [31:0] pc, input logic exp);
    lk_req = 1'b1;
    lk_pc  = pc;
    check({tag, "_ready"}, lk_ready, 1'b1);
    tick();
    check({tag, "_vld"}, lk_vld, 1'b1);
    check({tag, "_pred"}, lk_pred, exp);
    lk_req = 1'b0;
    tick();
    check({tag, "_vld_drop"}, lk_vld, 1'b0);
    check({tag, "_pred_hold"}, lk_pred, exp);
  endtask

  task automatic enq(input string tag, input logic [31:0] pc, input logic t);
    up_valid = 1'b1;
    up_pc    = pc;
    up_taken = t;
    check({tag, "_up_ready"}, up_ready, 1'b1);
    tick();
    up_valid = 1'b0;
  endtask

  // Counts cycles with busy_init high; pushes two taken updates to pc 0x300 when asked.
  task automatic sweep(input string tag, input logic push_during);
    int n = 0;
    int bad = 0;
    while (busy_init && n < 2000) begin
      if (lk_ready !== 1'b0) bad++;
      if (up_ready !== 1'b1) bad++;
      if (push_during && n == 10) begin
        up_valid = 1'b1;
        up_pc    = 32'h300;
        up_taken = 1'b1;
      end
      if (n == 12) up_valid = 1'b0;
      n++;
      tick();
    end
    check({tag, "_cycles"}, n, 1024);
    check({tag, "_ready_during"}, bad, 0);
    check({tag, "_lk_ready_after"}, lk_ready, 1'b1);
  endtask

  initial begin
    // Reset state
    idle(3);
    check("rst_busy", busy_init, 1'b1);
    check("rst_lk_ready", lk_ready, 1'b0);
    check("rst_up_ready", up_ready, 1'b1);
    check("rst_lk_vld", lk_vld, 1'b0);
    check("rst_lk_pred", lk_pred, 1'b0);
    check("rst_state", dbg_state, S_INIT);
    RESET = 1'b1;
    sweep("sweep1", 1'b1);

    lookup("first_lk", 32'h400, 1'b0);
    idle(4);
    lookup("init_queued", 32'h300, 1'b1);

    // Saturating counter walk on pc 0x1000
    enq("t1", 32'h1000, 1'b1); enq("t2", 32'h1000, 1'b1); enq("t3", 32'h1000, 1'b1);
    idle(8);
    lookup("ctr_11", 32'h1000, 1'b1);
    enq("n1", 32'h1000, 1'b0); idle(4);
    lookup("ctr_10", 32'h1000, 1'b1);
    enq("n2", 32'h1000, 1'b0); idle(4);
    lookup("ctr_01", 32'h1000, 1'b0);
    enq("n3", 32'h1000, 1'b0); enq("n4", 32'h1000, 1'b0);
    enq("n5", 32'h1000, 1'b0); enq("n6", 32'h1000, 1'b0);
    idle(10);
    enq("t4", 32'h1000, 1'b1); idle(4);
    lookup("ctr_sat0_01", 32'h1000, 1'b0);
    enq("t5", 32'h1000, 1'b1); idle(4);
    lookup("ctr_10b", 32'h1000, 1'b1);
    enq("t6", 32'h1000, 1'b1); enq("t7", 32'h1000, 1'b1); enq("t8", 32'h1000, 1'b1);
    idle(8);
    enq("n7", 32'h1000, 1'b0); idle(4);
    lookup("ctr_sat3_10", 32'h1000, 1'b1);

    // Aliasing: pc 0x8 and 0x1008 share index 2
    enq("a1", 32'h8, 1'b1); enq("a2", 32'h8, 1'b1);
    idle(6);
    lookup("alias", 32'h1008, 1'b1);
    lookup("alias_nb", 32'hC, 1'b0);

    // Contention: lookups every cycle while four updates fill the FIFO
    lk_req = 1'b1;
    lk_pc  = 32'h40;
    enq("c1", 32'h80, 1'b1); enq("c2", 32'h80, 1'b1);
    enq("c3", 32'h84, 1'b1); enq("c4", 32'h84, 1'b1);
    check("full_up_ready", up_ready, 1'b0);
    check("full_lk_ready", lk_ready, 1'b0);
    check("full_lk_vld_last", lk_vld, 1'b1);
    check("full_state_idle", dbg_state, 2'd1);
    tick();
    check("full2_lk_vld", lk_vld, 1'b0);
    check("full2_lk_ready", lk_ready, 1'b0);
    check("full2_up_ready", up_ready, 1'b0);
    check("full2_state_wr", dbg_state, S_WR);
    tick();
    check("pop_lk_ready", lk_ready, 1'b1);
    check("pop_up_ready", up_ready, 1'b1);
    check("pop_lk_vld", lk_vld, 1'b0);
    tick();
    check("resume_lk_vld", lk_vld, 1'b1);
    check("resume_lk_pred", lk_pred, 1'b0);
    lk_req = 1'b0;
    idle(10);
    lookup("cont_idx32", 32'h80, 1'b1);
    lookup("cont_idx33", 32'h84, 1'b1);

    // Hazard: lookup lands between read and write of an update
    enq("h0", 32'h100, 1'b1); idle(4);
    enq("h1", 32'h100, 1'b1);
    tick();
    check("hz_state_wr", dbg_state, S_WR);
    lk_req = 1'b1;
    lk_pc  = 32'h100;
    tick();
    check("hz_vld", lk_vld, 1'b1);
    check("hz_pred_old", lk_pred, 1'b0);
    check("hz_still_wr", dbg_state, S_WR);
    lk_req = 1'b0;
    tick();
    lookup("hz_after", 32'h100, 1'b1);

    // Mid-operation reset with three queued updates and the FSM in WR
    lk_req = 1'b1;
    lk_pc  = 32'h1000;
    enq("r1", 32'h200, 1'b1); enq("r2", 32'h200, 1'b1); enq("r3", 32'h200, 1'b1);
    check("pre_rst_pred", lk_pred, 1'b1);
    lk_req = 1'b0;
    tick();
    check("pre_rst_wr", dbg_state, S_WR);
    RESET = 1'b0;
    #1;
    check("mid_rst_state", dbg_state, S_INIT);
    check("mid_rst_busy", busy_init, 1'b1);
    check("mid_rst_up_ready", up_ready, 1'b1);
    check("mid_rst_lk_vld", lk_vld, 1'b0);
    check("mid_rst_lk_pred", lk_pred, 1'b0);
    idle(2);
    RESET = 1'b1;
    sweep("sweep2", 1'b0);
    idle(10);
    lookup("post_q_dropped", 32'h200, 1'b0);
    lookup("post_idx0", 32'h1000, 1'b0);
    lookup("post_idx2", 32'h8, 1'b0);
    lookup("post_idx32", 32'h80, 1'b0);
    lookup("post_idx64", 32'h100, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
